// File: rtl/psr_pkg.sv
// Shared definitions for the CPSR/SPSR bank controller: mode encodings,
// bank and exception indices, exception priority, vector offsets and FSM states.
// Optional build macro: PSR_VIRT_MODES_EN adds the mon and hyp SPSR banks.
package psr_pkg;

   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_FIQ = 5'b10001;
   localparam logic [4:0] MODE_IRQ = 5'b10010;
   localparam logic [4:0] MODE_SVC = 5'b10011;
   localparam logic [4:0] MODE_MON = 5'b10110;
   localparam logic [4:0] MODE_ABT = 5'b10111;
   localparam logic [4:0] MODE_HYP = 5'b11010;
   localparam logic [4:0] MODE_UND = 5'b11011;
   localparam logic [4:0] MODE_SYS = 5'b11111;

   // CPSR control bit positions
   localparam int CPSR_I = 7;
   localparam int CPSR_F = 6;
   localparam int CPSR_T = 5;

   typedef enum logic [2:0] {
      BK_FIQ, BK_IRQ, BK_SVC, BK_ABT, BK_UND
`ifdef PSR_VIRT_MODES_EN
      , BK_MON, BK_HYP
`endif
   } bank_e;

`ifdef PSR_VIRT_MODES_EN
   localparam int NUM_BANKS = 7;
`else
   localparam int NUM_BANKS = 5;
`endif

   // Bit positions inside exc_req {abt,fiq,irq,und,svc}
   typedef enum logic [2:0] {
      EXC_SVC = 3'd0, EXC_UND = 3'd1, EXC_IRQ = 3'd2, EXC_FIQ = 3'd3, EXC_ABT = 3'd4
   } exc_e;

   typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_SWITCH} state_e;

   typedef struct packed {
      logic  vld;
      bank_e idx;
   } bank_sel_t;

   typedef struct packed {
      logic vld;
      exc_e idx;
   } exc_sel_t;

   // Which SPSR bank a mode owns; vld=0 for usr/sys and unbanked encodings
   function automatic bank_sel_t mode_bank(input logic [4:0] m);
      bank_sel_t s;
      s = '{vld: 1'b1, idx: BK_FIQ};
      case (m)
         MODE_FIQ: s.idx = BK_FIQ;
         MODE_IRQ: s.idx = BK_IRQ;
         MODE_SVC: s.idx = BK_SVC;
         MODE_ABT: s.idx = BK_ABT;
         MODE_UND: s.idx = BK_UND;
`ifdef PSR_VIRT_MODES_EN
         MODE_MON: s.idx = BK_MON;
         MODE_HYP: s.idx = BK_HYP;
`endif
         default:  s.vld = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic mode_legal(input logic [4:0] m);
      return mode_bank(m).vld || (m == MODE_USR) || (m == MODE_SYS);
   endfunction

   // Fixed priority: abt > fiq > irq > und > svc
   function automatic exc_sel_t pick_exc(input logic [4:0] req);
      exc_sel_t s;
      s = '{vld: 1'b1, idx: EXC_SVC};
      if (req[EXC_ABT])      s.idx = EXC_ABT;
      else if (req[EXC_FIQ]) s.idx = EXC_FIQ;
      else if (req[EXC_IRQ]) s.idx = EXC_IRQ;
      else if (req[EXC_UND]) s.idx = EXC_UND;
      else if (req[EXC_SVC]) s.idx = EXC_SVC;
      else                   s.vld = 1'b0;
      return s;
   endfunction

   function automatic logic [7:0] vec_off(input exc_e e);
      case (e)
         EXC_UND: return 8'h04;
         EXC_SVC: return 8'h08;
         EXC_ABT: return 8'h10;
         EXC_IRQ: return 8'h18;
         EXC_FIQ: return 8'h1C;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [4:0] exc_mode(input exc_e e);
      case (e)
         EXC_UND: return MODE_UND;
         EXC_SVC: return MODE_SVC;
         EXC_ABT: return MODE_ABT;
         EXC_IRQ: return MODE_IRQ;
         EXC_FIQ: return MODE_FIQ;
         default: return MODE_SVC;
      endcase
   endfunction

   function automatic bank_e exc_bank(input exc_e e);
      case (e)
         EXC_UND: return BK_UND;
         EXC_SVC: return BK_SVC;
         EXC_ABT: return BK_ABT;
         EXC_IRQ: return BK_IRQ;
         EXC_FIQ: return BK_FIQ;
         default: return BK_SVC;
      endcase
   endfunction

endpackage

// File: rtl/psr_spsr_bank.sv
// Banked SPSR storage: one write port, one read port, both indexed by bank.
// Optional build macro: PSR_VIRT_MODES_EN (sets bank count via psr_pkg).
module psr_spsr_bank
   import psr_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  bank_e             widx_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  bank_e             ridx_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [NUM_BANKS];

   // Bank write; asynchronous clear wipes every bank
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_BANKS; i++) mem_q[i] <= '0;
      end else if (we_i && (int'(widx_i) < NUM_BANKS)) begin
         mem_q[widx_i] <= wdata_i;
      end
   end

   assign rdata_o = (int'(ridx_i) < NUM_BANKS) ? mem_q[ridx_i] : '0;

endmodule

// File: rtl/psr_bank_ctrl.sv
// CPSR plus banked SPSRs with exception-entry sequencer (IDLE->SAVE->SWITCH),
// MSR byte-masked writes, S-suffix flag update and exception return.
// Optional build macro: PSR_VIRT_MODES_EN adds mon/hyp modes and banks.
module psr_bank_ctrl
   import psr_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter logic [7:0]  RESET_LO8 = 8'h10,
   parameter logic [31:0] VEC_BASE  = 32'h0000_0000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [4:0]        exc_req_i,
   output logic              exc_ack_o,
   output logic [DATA_W-1:0] vec_addr_o,
   output logic              busy_o,
   input  logic              msr_wr_i,
   input  logic              msr_spsr_i,
   input  logic [3:0]        msr_mask_i,
   input  logic [DATA_W-1:0] msr_data_i,
   input  logic              s_upd_i,
   input  logic [3:0]        nzcv_i,
   input  logic              exc_ret_i,
   output logic              ret_err_o,
   output logic [DATA_W-1:0] cpsr_o,
   output logic [DATA_W-1:0] spsr_cur_o
);

   state_e            state_q, state_d;
   exc_e              exc_q;
   logic [DATA_W-1:0] cpsr_q, cpsr_d;
   logic [DATA_W-1:0] vec_q, vec_d;
   logic              ack_q, ack_d;
   logic              ret_err_q, ret_err_d;

   logic              bank_we;
   bank_e             bank_widx;
   logic [DATA_W-1:0] bank_wdata;
   logic [DATA_W-1:0] bank_rdata;
   logic [DATA_W-1:0] spsr_merge;

   logic [4:0]        req_unmasked;
   exc_sel_t          win;
   bank_sel_t         cur;
   logic              idle_op;

   // irq gated by I, fiq gated by F; abt/und/svc can never be masked
   assign req_unmasked = exc_req_i & ~{1'b0, cpsr_q[CPSR_F], cpsr_q[CPSR_I], 2'b00};
   assign win          = pick_exc(req_unmasked);
   assign cur          = mode_bank(cpsr_q[4:0]);
   assign idle_op      = (state_q == ST_IDLE) && !win.vld;

   psr_spsr_bank #(.DATA_W(DATA_W)) u_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (bank_we),
      .widx_i  (bank_widx),
      .wdata_i (bank_wdata),
      .ridx_i  (cur.idx),
      .rdata_o (bank_rdata)
   );

   assign spsr_cur_o = cur.vld ? bank_rdata : '0;

   // Sequencer state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Sequencer next state: any unmasked request starts an entry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (win.vld) state_d = ST_SAVE;
         ST_SAVE:   state_d = ST_SWITCH;
         ST_SWITCH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // MSR-to-SPSR data: masked bytes of the current SPSR replaced
   always_comb begin
      spsr_merge = spsr_cur_o;
      for (int b = 0; b < 4; b++)
         if (msr_mask_i[b]) spsr_merge[b*8 +: 8] = msr_data_i[b*8 +: 8];
   end

   // Sequencer outputs and PSR next-state; IDLE ops only when no entry starts
   always_comb begin
      busy_o     = (state_q != ST_IDLE) || win.vld;
      cpsr_d     = cpsr_q;
      vec_d      = '0;
      ack_d      = 1'b0;
      ret_err_d  = 1'b0;
      bank_we    = 1'b0;
      bank_widx  = cur.idx;
      bank_wdata = spsr_merge;
      case (state_q)
         ST_SAVE: begin
            bank_we    = 1'b1;
            bank_widx  = exc_bank(exc_q);
            bank_wdata = cpsr_q;
         end
         ST_SWITCH: begin
            cpsr_d[4:0]    = exc_mode(exc_q);
            cpsr_d[CPSR_I] = 1'b1;
            cpsr_d[CPSR_T] = 1'b0;
            if (exc_q == EXC_FIQ) cpsr_d[CPSR_F] = 1'b1;
            ack_d = 1'b1;
            vec_d = DATA_W'(VEC_BASE) + DATA_W'(vec_off(exc_q));
         end
         default: begin
            if (idle_op) begin
               if (exc_ret_i) begin
                  // restore wins over any MSR/flag write in the same cycle
                  if (cur.vld) cpsr_d = bank_rdata;
                  else         ret_err_d = 1'b1;
               end else begin
                  if (msr_wr_i && !msr_spsr_i) begin
                     for (int b = 1; b < 4; b++)
                        if (msr_mask_i[b]) cpsr_d[b*8 +: 8] = msr_data_i[b*8 +: 8];
                     if (msr_mask_i[0] && (cpsr_q[4:0] != MODE_USR) && mode_legal(msr_data_i[4:0]))
                        cpsr_d[7:0] = msr_data_i[7:0];
                  end
                  if (msr_wr_i && msr_spsr_i && cur.vld) bank_we = 1'b1;
                  if (s_upd_i) cpsr_d[31:28] = nzcv_i;
               end
            end
         end
      endcase
   end

   // PSR, winner latch and registered pulse outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cpsr_q    <= DATA_W'(RESET_LO8);
         exc_q     <= EXC_SVC;
         vec_q     <= '0;
         ack_q     <= 1'b0;
         ret_err_q <= 1'b0;
      end else begin
         cpsr_q    <= cpsr_d;
         vec_q     <= vec_d;
         ack_q     <= ack_d;
         ret_err_q <= ret_err_d;
         if ((state_q == ST_IDLE) && win.vld) exc_q <= win.idx;
      end
   end

   assign cpsr_o     = cpsr_q;
   assign exc_ack_o  = ack_q;
   assign vec_addr_o = vec_q;
   assign ret_err_o  = ret_err_q;

endmodule

// File: tb/tb_psr_bank_ctrl.sv
// Directed bench for psr_bank_ctrl: single-cycle IDLE ops from a vector table,
// hand-written sequences for exception entry, priority, masking and reset.
module tb_psr_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  exc_req;
   logic        exc_ack;
   logic [31:0] vec_addr;
   logic        busy;
   logic        msr_wr, msr_spsr, s_upd, exc_ret;
   logic [3:0]  msr_mask, nzcv;
   logic [31:0] msr_data;
   logic        ret_err;
   logic [31:0] cpsr, spsr_cur;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   psr_bank_ctrl dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .exc_req_i  (exc_req),
      .exc_ack_o  (exc_ack),
      .vec_addr_o (vec_addr),
      .busy_o     (busy),
      .msr_wr_i   (msr_wr),
      .msr_spsr_i (msr_spsr),
      .msr_mask_i (msr_mask),
      .msr_data_i (msr_data),
      .s_upd_i    (s_upd),
      .nzcv_i     (nzcv),
      .exc_ret_i  (exc_ret),
      .ret_err_o  (ret_err),
      .cpsr_o     (cpsr),
      .spsr_cur_o (spsr_cur)
   );

   typedef struct {
      logic        wr;
      logic        sp;
      logic [3:0]  mask;
      logic [31:0] data;
      logic        su;
      logic [3:0]  fl;
      logic        ret;
      logic [31:0] e_cpsr;
      logic [31:0] e_spsr;
      logic        e_err;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clr_ops();
      msr_wr = 0; msr_spsr = 0; msr_mask = 0; msr_data = 0;
      s_upd = 0; nzcv = 0; exc_ret = 0;
   endtask

   // Drive a request and wait (bounded) for exc_ack; checks latency and results
   task automatic enter(input string nm, input logic [4:0] req, input logic [4:0] req_after,
                        input logic [4:0] req_end, input bit noise,
                        input logic [31:0] e_cpsr, input logic [31:0] e_spsr,
                        input logic [31:0] e_vec);
      int n;
      bit got;
      exc_req = req;
      if (noise) begin
         msr_wr = 1; msr_mask = 4'hF; msr_data = 32'hFFFF_FFFF; s_upd = 1; nzcv = 4'hF;
      end
      #1 chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      clr_ops();
      exc_req = req_after;
      n = 0; got = 0;
      while (n < 8 && !got) begin
         if (exc_ack) got = 1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s_timeout: no exc_ack within %0d cycles, required 2", nm, n);
      end else begin
         chk({nm, "_lat"}, n, 32'd2);
         chk({nm, "_vec"}, vec_addr, e_vec);
         chk({nm, "_cpsr"}, cpsr, e_cpsr);
         chk({nm, "_spsr"}, spsr_cur, e_spsr);
      end
      exc_req = req_end;
      @(posedge clk); #1;
      chk({nm, "_ackpulse"}, {31'd0, exc_ack}, 32'd0);
   endtask

   task automatic op(input logic wr, input logic sp, input logic [3:0] mask, input logic [31:0] data,
                     input logic su, input logic [3:0] fl, input logic ret);
      msr_wr = wr; msr_spsr = sp; msr_mask = mask; msr_data = data;
      s_upd = su; nzcv = fl; exc_ret = ret;
      @(posedge clk); #1;
      clr_ops();
   endtask

   initial begin
      // starting state: svc mode, cpsr 0x93, SPSR_svc 0x10
      tbl[0]  = '{1, 1, 4'hF, 32'h2000_0010, 0, 4'h0, 0, 32'h0000_0093, 32'h2000_0010, 0};
      tbl[1]  = '{1, 0, 4'h1, 32'h0000_0014, 0, 4'h0, 0, 32'h0000_0093, 32'h2000_0010, 0};
      tbl[2]  = '{1, 0, 4'h1, 32'h0000_0016, 0, 4'h0, 0, 32'h0000_0093, 32'h2000_0010, 0};
      tbl[3]  = '{1, 0, 4'h8, 32'h5000_0000, 1, 4'hA, 0, 32'hA000_0093, 32'h2000_0010, 0};
      tbl[4]  = '{1, 0, 4'h6, 32'h00AB_CD00, 0, 4'h0, 0, 32'hA0AB_CD93, 32'h2000_0010, 0};
      tbl[5]  = '{1, 0, 4'h8, 32'h3F00_0000, 0, 4'h0, 0, 32'h3FAB_CD93, 32'h2000_0010, 0};
      tbl[6]  = '{0, 0, 4'h0, 32'h0000_0000, 1, 4'h4, 0, 32'h4FAB_CD93, 32'h2000_0010, 0};
      tbl[7]  = '{1, 0, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, 1, 32'h2000_0010, 32'h0000_0000, 0};
      tbl[8]  = '{0, 0, 4'h0, 32'h0000_0000, 0, 4'h0, 1, 32'h2000_0010, 32'h0000_0000, 1};
      tbl[9]  = '{1, 0, 4'h9, 32'hF000_001F, 0, 4'h0, 0, 32'hF000_0010, 32'h0000_0000, 0};
      tbl[10] = '{1, 1, 4'hF, 32'h1234_5678, 0, 4'h0, 0, 32'hF000_0010, 32'h0000_0000, 0};

      rst_n = 0; exc_req = 0; clr_ops();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      chk("rst_cpsr", cpsr, 32'h0000_0010);
      chk("rst_spsr", spsr_cur, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ack", {31'd0, exc_ack}, 32'd0);
      chk("rst_vec", vec_addr, 32'h0);
      chk("rst_reterr", {31'd0, ret_err}, 32'd0);

      enter("svc0", 5'b00001, 5'b00000, 5'b00000, 0, 32'h0000_0093, 32'h0000_0010, 32'h08);

      for (int i = 0; i < 11; i++) begin
         op(tbl[i].wr, tbl[i].sp, tbl[i].mask, tbl[i].data, tbl[i].su, tbl[i].fl, tbl[i].ret);
         chk($sformatf("v%0d_cpsr", i), cpsr, tbl[i].e_cpsr);
         chk($sformatf("v%0d_spsr", i), spsr_cur, tbl[i].e_spsr);
         chk($sformatf("v%0d_err", i), {31'd0, ret_err}, {31'd0, tbl[i].e_err});
      end

      // usr -> svc, then MSR into sys and back to svc with I clear
      enter("svc1", 5'b00001, 5'b00000, 5'b00000, 0, 32'hF000_0093, 32'hF000_0010, 32'h08);
      op(1, 0, 4'h9, 32'hF000_001F, 0, 4'h0, 0);
      chk("sys_cpsr", cpsr, 32'hF000_001F);
      chk("sys_spsr", spsr_cur, 32'h0);
      op(1, 0, 4'h9, 32'h6000_0013, 0, 4'h0, 0);
      chk("svc2_cpsr", cpsr, 32'h6000_0013);

      enter("irq", 5'b00100, 5'b00000, 5'b00000, 0, 32'h6000_0092, 32'h6000_0013, 32'h18);

      op(1, 1, 4'hF, 32'h2000_0010, 0, 4'h0, 0);
      chk("irq_spsrwr", spsr_cur, 32'h2000_0010);
      op(0, 0, 4'h0, 32'h0, 0, 4'h0, 1);
      chk("ret_cpsr", cpsr, 32'h2000_0010);
      chk("ret_spsr", spsr_cur, 32'h0);

      // abt beats irq; later request change ignored; ops in start cycle dropped
      enter("abt", 5'b10100, 5'b00001, 5'b00100, 1, 32'h2000_0097, 32'h2000_0010, 32'h10);
      chk("abt_irqmasked_busy", {31'd0, busy}, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("abt_noreentry", {31'd0, exc_ack}, 32'd0);
      end
      chk("abt_cpsr_hold", cpsr, 32'h2000_0097);
      exc_req = 0;

      enter("fiq", 5'b01000, 5'b00000, 5'b00000, 0, 32'h2000_00D1, 32'h2000_0097, 32'h1C);
      enter("und", 5'b00010, 5'b00000, 5'b00000, 0, 32'h2000_00DB, 32'h2000_00D1, 32'h04);

      // reset asserted while in SAVE
      exc_req = 5'b00001;
      @(posedge clk); #1;
      chk("save_busy", {31'd0, busy}, 32'd1);
      exc_req = 0;
      rst_n = 0;
      #1;
      chk("midrst_cpsr", cpsr, 32'h0000_0010);
      chk("midrst_spsr", spsr_cur, 32'h0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk) rst_n = 1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("midrst_noack", {31'd0, exc_ack}, 32'd0);
      end
      chk("midrst_cpsr2", cpsr, 32'h0000_0010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
